// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: sequential AES-128 key schedule. Accepts a 128-bit cipher key, then
// produces one round key per clock into an 11-entry table rk[0]..rk[10].
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   key_valid/key_ready cipher-key handshake (key_in sampled on acceptance only)
//   key_in              cipher key, byte 0 in [127:120]
//   busy                expansion in progress
//   keys_valid          table complete for the last accepted key
//   rk_sel / rk_out     combinational table read; indices 11..15 read as zero
module aes_key_expand_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rk_sel,
  output logic [127:0] rk_out
);

  typedef enum logic [0:0] {StIdle, StExpand} state_e;

  state_e       r_state;
  state_e       w_state_next;
  logic [3:0]   r_round;
  logic [7:0]   r_rcon;
  logic         r_keys_valid;
  logic [127:0] r_rk [0:10];

  logic         w_accept;
  logic [3:0]   w_prev_idx;
  logic [127:0] w_prev;
  logic [127:0] w_next;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned k);
    return (a << k) | (a >> (8 - k));
  endfunction

  // S-box = affine(a^254); a^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // One key-schedule round applied to the previous round key.
  always_comb begin
    logic [31:0] t;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    w_prev_idx = r_round - 4'd1;
    w_prev     = (w_prev_idx <= 4'd10) ? r_rk[w_prev_idx] : '0;
    t  = sub_rot_word(w_prev[31:0]) ^ {r_rcon, 24'h000000};
    w0 = w_prev[127:96] ^ t;
    w1 = w_prev[95:64]  ^ w0;
    w2 = w_prev[63:32]  ^ w1;
    w3 = w_prev[31:0]   ^ w2;
    w_next = {w0, w1, w2, w3};
  end

  assign w_accept = key_valid && key_ready;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_next = StExpand;
      StExpand: if (r_round == 4'd10) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    key_ready = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      StIdle:   key_ready = 1'b1;
      StExpand: busy      = 1'b1;
      default:  key_ready = 1'b1;
    endcase
  end

  // Round-key table, round counter and Rcon
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) r_rk[i] <= '0;
      r_round      <= 4'd0;
      r_rcon       <= 8'h01;
      r_keys_valid <= 1'b0;
    end else if (w_accept) begin
      r_rk[0]      <= key_in;
      r_round      <= 4'd1;
      r_rcon       <= 8'h01;
      r_keys_valid <= 1'b0;
    end else if (r_state == StExpand) begin
      r_rk[r_round] <= w_next;
      r_rcon        <= xtime(r_rcon);
      if (r_round == 4'd10) begin
        r_round      <= 4'd0;
        r_keys_valid <= 1'b1;
      end else begin
        r_round <= r_round + 4'd1;
      end
    end
  end

  assign keys_valid = r_keys_valid;

  always_comb begin
    rk_out = '0;
    if (rk_sel <= 4'd10) rk_out = r_rk[rk_sel];
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Testbench for aes_key_expand_seq: directed sequence with random keys, checked against a
// word-oriented key-schedule model built from an exp/log-table S-box.
module tb_aes_key_expand_seq;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rk_sel;
  logic [127:0] rk_out;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [127:0] ref_rk [11];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes_key_expand_seq dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rk_sel     (rk_sel),
    .rk_out     (rk_out)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from powers of the generator 3: inverse(x) = 3^(255 - log3(x)), then bitwise affine.
  task automatic build_sbox();
    logic [7:0] exp_t [255];
    int         log_t [256];
    logic [7:0] a;
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    a = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = a;
      log_t[a] = i;
      a = a ^ xt(a);
    end
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8] ^
               inv[(b + 7) % 8] ^ c[b];
      sb[x] = s;
    end
  endtask

  // FIPS-197 KeyExpansion over the 44-word array.
  task automatic ref_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rcon_tab[i / 4 - 1], 24'h000000};
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic check_table(input string tag);
    logic [127:0] exp;
    for (int j = 0; j < 16; j++) begin
      rk_sel = j[3:0];
      #1;
      exp = '0;
      if (j <= 10) exp = ref_rk[j];
      check($sformatf("%s_rk[%0d]", tag, j), rk_out, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int j = 0; j < 16; j++) begin
      rk_sel = j[3:0];
      #1;
      check($sformatf("%s_rk[%0d]", tag, j), rk_out, 128'h0);
    end
  endtask

  // Called at a negedge with the block idle: offers key, follows it edge by edge, and
  // returns at the negedge after keys_valid rises. hold_junk keeps key_valid high with
  // changing junk keys during the expansion, which must be ignored.
  task automatic expand(input logic [127:0] key, input bit hold_junk);
    ref_expand(key);
    key_valid = 1'b1;
    key_in    = key;
    for (int e = 0; e <= 10; e++) begin
      @(negedge clk);
      if (e == 0) key_valid = hold_junk;
      if (e == 9) key_valid = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      check($sformatf("busy_e%0d", e), 128'(busy), 128'(e < 10));
      check($sformatf("keys_valid_e%0d", e), 128'(keys_valid), 128'(e == 10));
      check($sformatf("key_ready_e%0d", e), 128'(key_ready), 128'(e == 10));
      rk_sel = e[3:0];
      #1;
      check($sformatf("rk_progress_e%0d", e), rk_out, ref_rk[e]);
    end
    check_table("table");
  endtask

  initial begin
    logic [127:0] k;
    build_sbox();
    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rk_sel    = '0;
    repeat (2) @(negedge clk);
    check("reset_key_ready", 128'(key_ready), 128'h1);
    check("reset_busy", 128'(busy), 128'h0);
    check("reset_keys_valid", 128'(keys_valid), 128'h0);
    check_all_zero("reset");

    // First key on the first edge after reset release; junk held on key_valid meanwhile.
    rst = 1'b0;
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    rk_sel = 4'd1;
    #1 check("fips_rk1", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
    rk_sel = 4'd10;
    #1 check("fips_rk10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Back-to-back: offered on the cycle keys_valid rose.
    expand(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    rk_sel = 4'd10;
    #1 check("seq_rk10", rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    rk_sel = 4'd0;
    #1 check("seq_rk0", rk_out, 128'h000102030405060708090a0b0c0d0e0f);

    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k, 1'($urandom_range(0, 1)));
    end

    // Reset while the round counter is 5 (after edges E0..E0+4).
    key_valid = 1'b1;
    key_in    = {$urandom, $urandom, $urandom, $urandom};
    for (int e = 0; e < 5; e++) begin
      @(negedge clk);
      key_valid = 1'b0;
    end
    check("mid_busy_before", 128'(busy), 128'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 128'(busy), 128'h0);
    check("mid_rst_keys_valid", 128'(keys_valid), 128'h0);
    check("mid_rst_key_ready", 128'(key_ready), 128'h1);
    check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", 128'(busy), 128'h0);
    check_all_zero("post_rst");
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
